// File: rtl/npu_pkg.sv
// Shared NPU definitions for the FRAM access path: write-request struct,
// bank extraction helper and default scheduler sizing.
package npu_pkg;

  localparam int FRAM_ADDR_W   = 12;
  localparam int DATA_W        = 32;
  localparam int FRAM_BANK_NUM = 4;
  localparam int BANK_W        = $clog2(FRAM_BANK_NUM);

  localparam int WBUF_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef logic [FRAM_ADDR_W-1:0] fram_addr_t;
  typedef logic [DATA_W-1:0]      fram_data_t;

  typedef struct packed {
    fram_addr_t addr;
    fram_data_t data;
  } fram_wreq_t;

  // Bank is the top address bits.
  function automatic logic [BANK_W-1:0] fram_bank_of(input fram_addr_t addr);
    return addr[FRAM_ADDR_W-1 -: BANK_W];
  endfunction

endpackage

// File: rtl/fram_access_sched_if.sv
// Bundle between compute unit / FRAM router and the access scheduler.
// master = environment (CU + router), slave = scheduler.
interface fram_access_sched_if;
  import npu_pkg::*;

  logic       rd_valid;
  logic       rd_ready;
  fram_addr_t rd_addr;
  logic       rd_rvalid;
  fram_data_t rd_rdata;
  logic       wr_valid;
  logic       wr_ready;
  fram_addr_t wr_addr;
  fram_data_t wr_data;
  logic       wbuf_empty;
  fram_addr_t rp_addr;
  fram_data_t rp_rdata;
  fram_addr_t wp_addr;
  fram_data_t wp_wdata;
  logic       wp_en;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rp_rdata,
    input  rd_ready, rd_rvalid, rd_rdata, wr_ready, wbuf_empty,
           rp_addr, wp_addr, wp_wdata, wp_en
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rp_rdata,
    output rd_ready, rd_rvalid, rd_rdata, wr_ready, wbuf_empty,
           rp_addr, wp_addr, wp_wdata, wp_en
  );

endinterface

// File: rtl/fram_wbuf.sv
// In-order write buffer. Entries are exposed oldest-first (index 0 = head)
// with valid bits so the scheduler can do hazard and newest-match lookups.
module fram_wbuf
  import npu_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fram_wreq_t       push_req,
  input  logic             pop,
  output fram_wreq_t       head,
  output logic             empty,
  output logic             full,
  output fram_wreq_t       ent [DEPTH],
  output logic [DEPTH-1:0] ent_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] count;
  fram_wreq_t  mem [DEPTH];

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr_reg[AW-1:0]] <= push_req;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [AW:0] slot;
      assign slot          = rd_ptr_reg + (AW+1)'(gi);
      assign ent[gi]       = mem[slot[AW-1:0]];
      assign ent_valid[gi] = ((AW+1)'(gi) < count);
    end
  endgenerate

endmodule

// File: rtl/fram_access_sched.sv
// FRAM access scheduler: one read and one write per cycle, never to the same bank.
// Define FRAM_RAW_FWD_EN to forward buffered write data to hazardous reads.
module fram_access_sched
  import npu_pkg::*;
#(
  parameter int WBUF_DEPTH   = WBUF_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  fram_access_sched_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  fram_wreq_t            head;
  fram_wreq_t            ent [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] ent_valid;
  logic [WBUF_DEPTH-1:0] ent_match;
  logic                  empty;
  logic                  full;
  logic                  hazard;
  logic                  starved;
  logic                  rd_issue;
  logic                  conflict;
  logic                  wr_issue;
  logic [SW-1:0]         starve_cnt_reg;
  logic                  rvalid_reg;

  fram_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.wr_valid && !full),
    .push_req ('{addr: bus.wr_addr, data: bus.wr_data}),
    .pop      (wr_issue),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .ent      (ent),
    .ent_valid(ent_valid)
  );

  generate
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_match
      assign ent_match[gi] = ent_valid[gi] && (ent[gi].addr == bus.rd_addr);
    end
  endgenerate

  assign hazard  = |ent_match;
  assign starved = (starve_cnt_reg == STARVE_MAX);

`ifdef FRAM_RAW_FWD_EN
  assign bus.rd_ready = !starved;
`else
  assign bus.rd_ready = !starved && !hazard;
`endif

  assign rd_issue = bus.rd_valid && bus.rd_ready;
  // Read wins a bank collision; the write waits and the starvation counter runs.
  assign conflict = !empty && rd_issue &&
                    (fram_bank_of(bus.rd_addr) == fram_bank_of(head.addr));
  assign wr_issue = !empty && !conflict;

  assign bus.rp_addr    = rd_issue ? bus.rd_addr : '0;
  assign bus.wp_en      = wr_issue;
  assign bus.wp_addr    = empty ? '0 : head.addr;
  assign bus.wp_wdata   = empty ? '0 : head.data;
  assign bus.wr_ready   = !full;
  assign bus.wbuf_empty = empty;
  assign bus.rd_rvalid  = rvalid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      rvalid_reg     <= 1'b0;
    end else begin
      rvalid_reg <= rd_issue;
      if (empty || wr_issue)
        starve_cnt_reg <= '0;
      else if (conflict && !starved)
        starve_cnt_reg <= starve_cnt_reg + STARVE_ONE;
    end
  end

`ifdef FRAM_RAW_FWD_EN
  fram_data_t fwd_data;
  fram_data_t fwd_data_reg;
  logic       fwd_hit_reg;

  // Later (younger) matches override earlier ones: newest write wins.
  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++)
      if (ent_match[i])
        fwd_data = ent[i].data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      fwd_hit_reg  <= rd_issue && hazard;
      fwd_data_reg <= fwd_data;
    end
  end

  assign bus.rd_rdata = !rvalid_reg ? '0 :
                        (fwd_hit_reg ? fwd_data_reg : bus.rp_rdata);
`else
  assign bus.rd_rdata = rvalid_reg ? bus.rp_rdata : '0;
`endif

endmodule

// File: tb/tb_fram_access_sched.sv
// Self-checking bench for fram_access_sched: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_fram_access_sched;
  import npu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef FRAM_RAW_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;

  fram_access_sched_if bus();

  fram_access_sched #(.WBUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  logic [31:0] router_mem [4096];
  logic [31:0] model_mem  [4096];

  // Router: registered read (one-cycle BRAM latency), write on wp_en.
  always @(posedge clk) begin
    bus.rp_rdata <= router_mem[bus.rp_addr];
    if (bus.wp_en === 1'b1)
      router_mem[bus.wp_addr] <= bus.wp_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         mq[$];
  int          m_starve = 0;
  bit          m_rv = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          hz, e_ready, e_rissue, e_wissue, wr_ok;
  logic [31:0] fv;
  int          ra;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
      m_rv     = 1'b0;
      chk("rst_rd_ready",   bus.rd_ready,   1);
      chk("rst_wr_ready",   bus.wr_ready,   1);
      chk("rst_wbuf_empty", bus.wbuf_empty, 1);
      chk("rst_rd_rvalid",  bus.rd_rvalid,  0);
      chk("rst_wp_en",      bus.wp_en,      0);
      chk("rst_rd_rdata",   bus.rd_rdata,   0);
    end else begin
      ra = int'(bus.rd_addr);
      hz = 1'b0;
      fv = '0;
      foreach (mq[i])
        if (mq[i].addr == ra) begin
          hz = 1'b1;
          fv = mq[i].data;
        end
      e_ready  = (m_starve < LIMIT) && (FWD || !hz);
      e_rissue = bus.rd_valid && e_ready;
      e_wissue = (mq.size() > 0) && !(e_rissue && (ra / 1024 == mq[0].addr / 1024));
      wr_ok    = mq.size() < DEPTH;

      chk("rd_ready",   bus.rd_ready,   e_ready);
      chk("wr_ready",   bus.wr_ready,   wr_ok);
      chk("wbuf_empty", bus.wbuf_empty, mq.size() == 0);
      chk("rp_addr",    bus.rp_addr,    e_rissue ? ra : 0);
      chk("wp_en",      bus.wp_en,      e_wissue);
      if (mq.size() > 0) begin
        chk("wp_addr",  bus.wp_addr,  mq[0].addr);
        chk("wp_wdata", bus.wp_wdata, mq[0].data);
      end
      chk("rd_rvalid", bus.rd_rvalid, m_rv);
      if (m_rv) begin
        chk("rd_rdata", bus.rd_rdata, m_rdata);
        if (verbose) $display("read  return data=%h", m_rdata);
      end

      m_rv = e_rissue;
      if (e_rissue)
        m_rdata = (FWD && hz) ? fv : model_mem[ra];
      if (e_wissue) begin
        if (verbose) $display("write retire addr=%h data=%h", mq[0].addr, mq[0].data);
        model_mem[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
        m_starve = 0;
      end else if (mq.size() > 0 && m_starve < LIMIT) begin
        m_starve++;
      end
      if (bus.wr_valid && wr_ok)
        mq.push_back('{int'(bus.wr_addr), bus.wr_data});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rv, input int a, input bit wv, input int wa, input logic [31:0] wd);
    bus.rd_valid = rv;
    bus.rd_addr  = FRAM_ADDR_W'(a);
    bus.wr_valid = wv;
    bus.wr_addr  = FRAM_ADDR_W'(wa);
    bus.wr_data  = wd;
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) * 1024) + ($urandom_range(0, 3) * 4);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      router_mem[i] = 32'hC0DE_0000 | i;
      model_mem[i]  = 32'hC0DE_0000 | i;
    end
    router_mem['h010] = 32'hAB;
    model_mem['h010]  = 32'hAB;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wbuf_empty", bus.wbuf_empty, 1);
    chk("reset_rd_ready",   bus.rd_ready,   1);
    step();
    rst_n = 1'b1;

    // Read latency: 0x010 returns 0xAB one cycle later.
    drive(1, 'h010, 0, 0, 0);
    @(negedge clk);
    chk("lat_rp_addr", bus.rp_addr, 'h010);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_rvalid", bus.rd_rvalid, 1);
    chk("lat_rdata",  bus.rd_rdata,  'hAB);
    chk("lat_wp_en",  bus.wp_en,     0);

    // Parallel issue: bank-0 write alongside bank-1 reads.
    step();
    drive(1, 'h400, 1, 'h020, 'h5A);
    @(negedge clk);
    chk("par_wp_en_c0", bus.wp_en, 0);
    step();
    drive(1, 'h404, 0, 0, 0);
    @(negedge clk);
    chk("par_wp_en_c1",  bus.wp_en,    1);
    chk("par_wp_addr",   bus.wp_addr,  'h020);
    chk("par_rd_ready",  bus.rd_ready, 1);

    // Starvation: reads hammer bank 0 while a bank-0 write waits.
    step();
    drive(1, 'h100, 1, 'h030, 'h77);
    for (int k = 1; k <= 10; k++) begin
      step();
      drive(1, 'h100, 0, 0, 0);
      @(negedge clk);
      chk("starve_rd_ready", bus.rd_ready, (k == 9) ? 0 : 1);
      chk("starve_wp_en",    bus.wp_en,    (k == 9) ? 1 : 0);
    end

    // FIFO fill: four bank-2 writes blocked by bank-2 reads, fifth held.
    for (int c = 0; c < 4; c++) begin
      step();
      drive(1, 'h900, 1, 'h800 + 4 * c, c + 1);
      @(negedge clk);
      chk("fill_wr_ready", bus.wr_ready, 1);
    end
    for (int c = 4; c < 10; c++) begin
      step();
      drive(1, 'h900, 1, 'h810, 5);
      @(negedge clk);
      chk("full_wr_ready", bus.wr_ready, 0);
      chk("full_wp_en",    bus.wp_en,    (c == 9) ? 1 : 0);
    end
    chk("full_first_addr", bus.wp_addr,  'h800);
    chk("full_first_data", bus.wp_wdata, 1);
    for (int c = 10; c < 14; c++) begin
      step();
      drive(0, 0, (c == 10), 'h810, 5);
      @(negedge clk);
      if (c == 10) chk("after_pop_wr_ready", bus.wr_ready, 1);
      chk("order_wp_en",   bus.wp_en,   1);
      chk("order_wp_addr", bus.wp_addr, 'h800 + 4 * (c - 9));
    end

`ifndef FRAM_RAW_FWD_EN
    // RAW without forwarding: read stalls until the write drains.
    step();
    drive(0, 0, 1, 'h0A0, 'h55);
    step();
    drive(1, 'h0A0, 0, 0, 0);
    @(negedge clk);
    chk("raw_stall_rd_ready", bus.rd_ready, 0);
    chk("raw_stall_wp_en",    bus.wp_en,    1);
    step();
    @(negedge clk);
    chk("raw_go_rd_ready", bus.rd_ready, 1);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_rvalid", bus.rd_rvalid, 1);
    chk("raw_rdata",  bus.rd_rdata,  'h55);
`else
    // RAW with forwarding: newest of two buffered writes is returned.
    step();
    drive(0, 0, 1, 'h0A0, 'h11);
    step();
    drive(1, 'h0B0, 1, 'h0A0, 'h22);
    step();
    drive(1, 'h0A0, 0, 0, 0);
    @(negedge clk);
    chk("fwd_rd_ready", bus.rd_ready, 1);
    step();
    drive(1, 'h0B4, 0, 0, 0);
    @(negedge clk);
    chk("fwd_rvalid", bus.rd_rvalid, 1);
    chk("fwd_rdata",  bus.rd_rdata,  'h22);
`endif

    // Reset mid-burst discards buffered writes and the in-flight read.
    step();
    drive(1, 'h0C0, 1, 'h0D0, 'h99);
    step();
    drive(1, 'h0C4, 1, 'h0D4, 'h9A);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wbuf_empty", bus.wbuf_empty, 1);
    chk("midrst_rd_rvalid",  bus.rd_rvalid,  0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Randomized traffic over 16 addresses in 4 banks.
    verbose = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_n = !(c == 2000 || c == 2001);
      drive($urandom_range(0, 99) < 65, rand_addr(),
            $urandom_range(0, 99) < 45, rand_addr(), $urandom);
    end
    step();
    drive(0, 0, 0, 0, 0);
    repeat (DEPTH + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fram_access_sched.md
# fram_access_sched

Access scheduler directly upstream of the FRAM router. It accepts independent read and write request streams from the compute unit and drives the router's single read port and single write port. It never issues a read and a write to the same bank in one cycle, buffers writes in an in-order FIFO, and returns read data after the one-cycle BRAM latency. A starvation counter guarantees that buffered writes drain under sustained read traffic.

## Interface
- `WBUF_DEPTH`, default 4: write buffer entries; must be a power of two and at least 2.
- `STARVE_LIMIT`, default 8: number of consecutive cycles the head write may be blocked before reads are held off.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_valid`  in  1  read request valid.
- `rd_ready`  out  1  read request accepted this cycle when high together with `rd_valid`.
- `rd_addr`  in  `FRAM_ADDR_RANGE`  read address.
- `rd_rvalid`  out  1  read data valid.
- `rd_rdata`  out  `DATA_RANGE`  read data.
- `wr_valid`  in  1  write request valid.
- `wr_ready`  out  1  write buffer not full.
- `wr_addr`  in  `FRAM_ADDR_RANGE`  write address.
- `wr_data`  in  `DATA_RANGE`  write data.
- `wbuf_empty`  out  1  no writes pending; used by the CU for flush and barrier.
- `rp_addr`  out  `FRAM_ADDR_RANGE`  to router read port.
- `rp_rdata`  in  `DATA_RANGE`  from router read port.
- `wp_addr`, `wp_wdata`, `wp_en`  out  `FRAM_ADDR_RANGE` / `DATA_RANGE` / 1  to router write port.

## Operation
- **Bank number:** bank of an address = its top `$clog2(FRAM_BANK_NUM)` bits.
- **Read issue:** a read is issued when `rd_valid && rd_ready`.
  - `rp_addr = rd_addr`, combinational.
  - When no read is issued, `rp_addr` is 0.
- **Write acceptance:** a write is accepted when `wr_valid && wr_ready`.
  - The entry is pushed to the FIFO tail.
  - Writes always pass through the FIFO; there is no same-cycle bypass.
- **Write issue:**
  - The head entry issues (`wp_en=1`, `wp_addr`/`wp_wdata` = head) when the FIFO is non-empty and one of these holds:
    - no read issues this cycle, or
    - the read bank differs from the head bank.
  - On issue, the head entry is popped.
  - `wp_addr` and `wp_wdata` show the head entry whenever the FIFO is non-empty.
- **Conflict:** when the read bank equals the head bank, the read wins and the write is blocked.
- **Starvation:**
  - `starve_cnt` increments each cycle the head is blocked by a conflict.
  - It clears on pop, or when the FIFO is empty.
  - While `starve_cnt == STARVE_LIMIT`, `rd_ready` is 0, so the head write issues that cycle.
- **RAW hazard:** a read whose address matches any valid FIFO entry. With `FRAM_RAW_FWD_EN` undefined, `rd_ready` is 0 during a hazard.
- **`rd_ready` equation:** `!(starve_cnt==STARVE_LIMIT) && !(hazard && !FWD)`. It does not depend on `rd_valid`.
- **`wr_ready`:** `!full`. No push is allowed when full, even in a cycle with a pop.
- **Ordering:** writes retire in acceptance order. Simultaneous push and pop is allowed when the FIFO is not full.

## Timing
- Read latency: a read accepted in cycle N gives `rd_rvalid=1` and `rd_rdata=rp_rdata` in N+1.
  - Back-to-back reads: one per cycle.
- Write latency: a write accepted in cycle N reaches the earliest `wp_en` in N+1.
- Reset values:
  - `rd_rvalid=0`
  - `wp_en=0`
  - `wbuf_empty=1`
  - `wr_ready=1`
  - `rd_ready=1`
  - FIFO pointers and `starve_cnt` = 0
  - `rd_rdata=0`
- Reset during operation discards all buffered writes and cancels any in-flight read response.
- FIFO pointers are `$clog2(WBUF_DEPTH)+1` bits.
  - Full: pointer LSBs equal and MSBs differ.
  - Pointers wrap naturally.
- `starve_cnt` saturates at `STARVE_LIMIT`. Its width is `$clog2(STARVE_LIMIT+1)`.

## Configuration
- `FRAM_RAW_FWD_EN` defined:
  - A hazardous read is accepted.
  - The data of the newest matching FIFO entry is captured in cycle N and returned in N+1 in place of `rp_rdata`.
  - This includes the head entry when it issues in the same cycle N.
- `FRAM_RAW_FWD_EN` undefined:
  - Hazardous reads stall until the matching entries have drained.
  - No forwarding mux or data capture register is built.

## Structure
- Shared package `npu_pkg`:
  - `fram_wreq_t` struct {addr, data}
  - `fram_bank_of()` function
  - default constants for `WBUF_DEPTH` and `STARVE_LIMIT`
- Sub-module `fram_wbuf`:
  - Parameterised FIFO of `fram_wreq_t`.
  - Exposes all entries and their valid bits for the hazard and forwarding compare.

## Test plan
- **Read latency:** reset, then read `addr=0x010`; FRAM holds `0xAB` → `rd_rvalid` and `0xAB` exactly one cycle later; `wp_en` stays 0.
- **Parallel issue:** write to bank 0 and continuous reads to bank 1 → the write issues the cycle after acceptance, in parallel with the reads.
- **Starvation:** continuous reads to the head write's bank with `STARVE_LIMIT=8` → `rd_ready` low on exactly cycle 9 of the conflict, write issues, reads resume.
- **FIFO fill:** accept 4 writes while reads block all banks → `wr_ready=0` and the 5th write is held; after one pop `wr_ready=1`; writes retire in order.
- **RAW without forwarding:** write `0x55` to A, then read A immediately → `FRAM_RAW_FWD_EN` off: `rd_ready=0` until the write issues, then read returns `0x55`.
- **RAW with forwarding:** writes `0x11` then `0x22` to A, then read A the next cycle → with `FRAM_RAW_FWD_EN`: read accepted, returns `0x22`; reset mid-burst → `wbuf_empty=1`, `rd_rvalid=0`.
